// File: rtl/button_debounce_encoder.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : button_debounce_encoder                                    |
// | Description : Input stage for the LED chaser game. Synchronises and      |
// |               debounces three raw push-buttons, detects press events     |
// |               and encodes each press into a registered 3-bit code with   |
// |               a one-cycle valid strobe.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk         in   1  system clock, rising edge                          |
// |   reset       in   1  asynchronous active-low reset                      |
// |   button_raw  in   3  raw bouncy asynchronous buttons, active-high       |
// |   btn_level   out  3  debounced level per button                        |
// |   btn_code    out  3  1/2/3 = button 0/1/2 pressed, 0 = none            |
// |   btn_valid   out  1  one-cycle strobe qualifying btn_code              |
// |   multi_press out  1  strobe with btn_valid when >1 press in one cycle  |
// +--------------------------------------------------------------------------+
// | Optional feature macro: BUTTON_AUTOREPEAT_EN                             |
// |   Defined   : held button re-emits its code after REPEAT_DELAY cycles    |
// |               and then every REPEAT_PERIOD cycles.                       |
// |   Undefined : no hold timer; a held button yields exactly one event.     |
// +--------------------------------------------------------------------------+
module button_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] button_raw,
  output logic [2:0] btn_level,
  output logic [2:0] btn_code,
  output logic       btn_valid,
  output logic       multi_press
);

  localparam logic [23:0] c_deb_last = 24'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the 24-bit counters cannot represent.
  generate
    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 16777215)) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range 2..2^24-1");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_DELAY > 16777215) ||
        (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > 16777215)) begin : g_bad_repeat
      $error("REPEAT_DELAY/REPEAT_PERIOD out of range 1..2^24-1");
    end
  endgenerate

  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_level;
  logic [2:0]  r_level_d;
  logic [23:0] r_cnt [3];
  logic [2:0]  r_code;
  logic        r_valid;
  logic        r_multi;

  logic [2:0]  w_press;
  logic [2:0]  w_press_code;
  logic        w_multi;
  logic        w_rep_fire;
  logic [2:0]  w_rep_code;

  // Two-flop synchroniser followed by per-button stability counters. The
  // counter only runs while the synchronised input disagrees with the
  // accepted level, so any glitch shorter than DEBOUNCE_CYCLES restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= button_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_deb_last) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 24'd1;
        end
      end
    end
  end

  // Press = debounced level rising; releases are ignored.
  assign w_press = r_level & ~r_level_d;
  assign w_multi = (w_press[0] & w_press[1]) | (w_press[0] & w_press[2]) |
                   (w_press[1] & w_press[2]);

  // Lowest pressed index wins the code.
  always_comb begin
    w_press_code = 3'd0;
    if (w_press[0]) begin
      w_press_code = 3'd1;
    end else if (w_press[1]) begin
      w_press_code = 3'd2;
    end else if (w_press[2]) begin
      w_press_code = 3'd3;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [23:0] c_rep_delay_last  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] c_rep_period_last = 24'(REPEAT_PERIOD - 1);

  logic [23:0] r_hold_cnt;
  logic        r_hold_rep;   // 0: waiting for first repeat, 1: periodic phase
  logic [2:0]  r_hold_code;  // code of the button the timer is tracking
  logic [2:0]  w_held_code;
  logic        w_held_same;

  always_comb begin
    w_held_code = 3'd0;
    if (r_level[0]) begin
      w_held_code = 3'd1;
    end else if (r_level[1]) begin
      w_held_code = 3'd2;
    end else if (r_level[2]) begin
      w_held_code = 3'd3;
    end
  end

  // The tracked button is still the lowest one held; any change (including
  // its release) restarts the timer on the next edge.
  assign w_held_same = (w_held_code != 3'd0) && (w_held_code == r_hold_code);
  assign w_rep_fire  = w_held_same &&
                       (r_hold_cnt == (r_hold_rep ? c_rep_period_last : c_rep_delay_last));
  assign w_rep_code  = r_hold_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_cnt  <= '0;
      r_hold_rep  <= 1'b0;
      r_hold_code <= 3'd0;
    end else if ((|w_press) || !w_held_same) begin
      r_hold_cnt  <= '0;
      r_hold_rep  <= 1'b0;
      r_hold_code <= w_held_code;
    end else if (w_rep_fire) begin
      r_hold_cnt <= '0;
      r_hold_rep <= 1'b1;
    end else begin
      r_hold_cnt <= r_hold_cnt + 24'd1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
  assign w_rep_code = 3'd0;
`endif

  // Registered encoder; a genuine press outranks a repeat in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_code  <= 3'd0;
      r_multi <= 1'b0;
    end else if (|w_press) begin
      r_valid <= 1'b1;
      r_code  <= w_press_code;
      r_multi <= w_multi;
    end else if (w_rep_fire) begin
      r_valid <= 1'b1;
      r_code  <= w_rep_code;
      r_multi <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_code  <= 3'd0;
      r_multi <= 1'b0;
    end
  end

  assign btn_level   = r_level;
  assign btn_code    = r_code;
  assign btn_valid   = r_valid;
  assign multi_press = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_encoder.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_button_debounce_encoder                                 |
// | Description : Scoreboard bench for button_debounce_encoder. Stimulus     |
// |               pushes expected events (code, multi, cycle); a monitor     |
// |               pops and compares on every btn_valid strobe.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_button_debounce_encoder;

  localparam int c_deb    = 4;
  localparam int c_rdelay = 10;
  localparam int c_rper   = 3;
  // Stimulus applied before edge 0 -> event visible at the negedge after
  // edge DEBOUNCE_CYCLES+2, i.e. cycle count + DEBOUNCE_CYCLES + 3.
  localparam int c_lat    = c_deb + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] button_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_code;
  logic       btn_valid;
  logic       multi_press;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] code;
    logic       multi;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  button_debounce_encoder #(
    .DEBOUNCE_CYCLES(c_deb),
    .REPEAT_DELAY   (c_rdelay),
    .REPEAT_PERIOD  (c_rper)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .btn_level  (btn_level),
    .btn_code   (btn_code),
    .btn_valid  (btn_valid),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] code, input logic multi, input int delay);
    exp_t e;
    e.code  = code;
    e.multi = multi;
    e.cyc   = cyc + delay;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the queue, in value and time.
  always @(negedge clk) begin : mon
    exp_t e;
    if (btn_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event_code", int'(btn_code), 0);
      end else begin
        e = exp_q.pop_front();
        check("event_code",  int'(btn_code),    int'(e.code));
        check("event_multi", int'(multi_press), int'(e.multi));
        check("event_cycle", cyc,               e.cyc);
      end
    end else begin
      check("idle_code",  int'(btn_code),    0);
      check("idle_multi", int'(multi_press), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    button_raw = 3'b000;
    @(negedge clk);
    check("reset_level", int'(btn_level),   0);
    check("reset_valid", int'(btn_valid),   0);
    check("reset_code",  int'(btn_code),    0);
    check("reset_multi", int'(multi_press), 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Clean press of button 1.
    button_raw = 3'b010;
    push(3'd2, 1'b0, c_lat);
    tick(9);
    check("level_press1", int'(btn_level), 3'b010);
    button_raw = 3'b000;
    tick(8);
    check("level_release1", int'(btn_level), 0);

    // Bounce on button 0, then stable high.
    button_raw = 3'b001; tick(1);
    button_raw = 3'b000; tick(1);
    button_raw = 3'b001; tick(1);
    button_raw = 3'b000; tick(1);
    button_raw = 3'b001;
    push(3'd1, 1'b0, c_lat);
    tick(9);
    check("level_bounce", int'(btn_level), 3'b001);
    button_raw = 3'b000;
    tick(8);
    check("level_release0", int'(btn_level), 0);

    // Simultaneous press of buttons 1 and 2.
    button_raw = 3'b110;
    push(3'd2, 1'b1, c_lat);
    tick(7);
    check("level_simul", int'(btn_level), 3'b110);

    // 2-cycle release: too short, level holds, no event.
    button_raw = 3'b000; tick(2);
    button_raw = 3'b110; tick(1);
    check("level_short_release", int'(btn_level), 3'b110);

    // 5-cycle release: accepted, then re-press button 2 alone.
    button_raw = 3'b000; tick(5);
    button_raw = 3'b100;
    push(3'd3, 1'b0, c_lat);
    tick(2);
    check("level_long_release", int'(btn_level), 0);
    tick(7);
    check("level_repress", int'(btn_level), 3'b100);

    // Asynchronous reset mid-operation with all buttons high.
    button_raw = 3'b111;
    tick(2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_level", int'(btn_level),   0);
    check("midrst_valid", int'(btn_valid),   0);
    check("midrst_code",  int'(btn_code),    0);
    check("midrst_multi", int'(multi_press), 0);
    tick(3);
    reset = 1'b1;
    push(3'd1, 1'b1, c_lat);
    tick(9);
    check("level_after_reset", int'(btn_level), 3'b111);
    button_raw = 3'b000;
    tick(8);
    check("level_release_all", int'(btn_level), 0);

    // Long hold of button 2.
    button_raw = 3'b100;
    push(3'd3, 1'b0, c_lat);
`ifdef BUTTON_AUTOREPEAT_EN
    push(3'd3, 1'b0, c_lat + c_rdelay);
    push(3'd3, 1'b0, c_lat + c_rdelay + c_rper);
    push(3'd3, 1'b0, c_lat + c_rdelay + 2 * c_rper);
`endif
    tick(9);
    check("level_hold", int'(btn_level), 3'b100);
    tick(10);
    button_raw = 3'b000;
    tick(12);
    check("level_hold_release", int'(btn_level), 0);
    check("pending_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_debounce_encoder.md
Name: button_debounce_encoder

Overview:
- Front-end input stage for the LED chaser game.
- Synchronizes and debounces the three raw push-buttons and detects the press events.
- Encodes each press into a registered 3-bit code with a one-cycle valid strobe.
- Its outputs feed the game's button input, so the game sees exactly one clean event per physical press.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a level change is accepted (10 ms at 25 MHz). Legal range is 2 to 2^24-1.
- REPEAT_DELAY, 12500000: cycles held before the first auto-repeat. Used only with the optional feature.
- REPEAT_PERIOD, 2500000: cycles between subsequent auto-repeats. Used only with the optional feature.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- button_raw, input, 3: raw, bouncy, asynchronous push-buttons, active-high.
- btn_level, output, 3: debounced level of each button.
- btn_code, output, 3: encoded press. 3'd1/2/3 means button 0/1/2 was pressed; 3'd0 means none.
- btn_valid, output, 1: one-cycle strobe qualifying btn_code.
- multi_press, output, 1: one-cycle strobe, asserted alongside btn_valid when more than one press was accepted in the same cycle.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All synchronizer flops, debounced levels, counters and output registers clear to 0.
  - Outputs during reset: btn_level = 0, btn_code = 0, btn_valid = 0, multi_press = 0.
  - Release from reset is synchronous to clk.
- Synchronizer: each button_raw bit passes through a 2-flop synchronizer; the second-flop output is sync[i].
- Per-button debounce, 24-bit counter cnt[i]:
  - If sync[i] == btn_level[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_level[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count and produces no change.
- Edge detect: press[i] = btn_level[i] rising, i.e. the cycle after btn_level[i] goes 0 to 1. Releases generate no event.
- Encoder, outputs registered:
  - If any press[i] is set: btn_valid <= 1 and btn_code <= lowest pressed index + 1.
  - multi_press <= 1 if two or more press[i] are set in that cycle.
  - Otherwise btn_valid <= 0, btn_code <= 0, multi_press <= 0.
  - btn_code holds 0 whenever btn_valid is 0.
- Latency:
  - Let edge 0 be the first clk edge at which button_raw[i] = 1 is captured by the first synchronizer flop, with the input stable thereafter.
  - Then btn_level[i] rises after edge DEBOUNCE_CYCLES+1, and btn_valid pulses after edge DEBOUNCE_CYCLES+2.
- Holding: a button held indefinitely yields exactly one btn_valid, unless the optional feature is enabled.
- Releases: a release must also be stable for DEBOUNCE_CYCLES cycles before btn_level drops and a new press becomes possible.
- Counter width: 24 bits; counters saturate logically by the compare above and never wrap.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - One shared 24-bit hold timer tracks the lowest-index button with btn_level = 1.
  - The timer restarts on every press event and whenever that button's btn_level falls.
  - After REPEAT_DELAY cycles held, a repeat event is generated; further repeats follow every REPEAT_PERIOD cycles.
  - A repeat pulses btn_valid with that button's code and multi_press = 0.
  - A genuine press in the same cycle takes priority, and the timer restarts.
- Undefined: no timer logic; a hold produces exactly one event.

Test Plan (simulate with DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3):
- Reset: assert reset low mid-operation with button_raw = 3'b111 -> all outputs 0 immediately; after release, btn_valid rises only after a fresh 4-cycle stable period.
- Clean press: button_raw[1] goes high and stays high -> exactly one btn_valid pulse with btn_code = 3'd2, 6 edges after first capture; btn_level[1] = 1 thereafter.
- Bounce: toggle button_raw[0] as 1,0,1,0 on consecutive cycles, then hold 1 -> no event during the bounce; one event, btn_code = 3'd1, after 4 stable cycles.
- Simultaneous: button_raw goes from 3'b000 to 3'b110 on the same edge -> one btn_valid with btn_code = 3'd2 and multi_press = 1; btn_level = 3'b110.
- Release/re-press: release for 2 cycles, then re-press -> no new event; release for 5 cycles, then re-press -> second event.
- With BUTTON_AUTOREPEAT_EN: hold button 2 -> press event, then repeats 10 cycles later and every 3 cycles after that, all with btn_code = 3'd3. Without the macro: exactly one event.
